// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared FSM state encodings and default frame width for the PISO transmitter.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - index of the data bit currently on the serial line; clear wins over enable.
module bit_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/piso_shift_tx.sv
// rtl/piso_shift_tx.sv - parallel-in serial-out transmitter; PISO_TX_PARITY_EN appends an even-parity bit.
module piso_shift_tx
  import shift_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
`ifndef PISO_TX_PARITY_EN
  localparam logic [CW-1:0] PEN_IDX  = CW'(WIDTH - 2);
`endif

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic             ser_q;
  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    cnt;
  logic             hs;
  logic             last_bit;
  logic             first_bit;
  logic             next_bit;
`ifdef PISO_TX_PARITY_EN
  logic             par_q;
`endif

  assign ready_out = (state_q == IDLE);
  assign hs        = valid_in & ready_out;
  assign last_bit  = (state_q == SHIFT) && (cnt == LAST_IDX);
  assign first_bit = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];

  // The register always holds the bit on the line at its outgoing end, so the
  // next bit is read from the already-shifted value.
  always_comb begin
    shreg_d  = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
    next_bit = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
  end

  bit_counter #(.CW(CW)) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (hs),
    .en   ((state_q == SHIFT) && !last_bit),
    .count(cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      ser_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (hs) begin
            state_q <= SHIFT;
            shreg_q <= data_in;
            ser_q   <= first_bit;
            busy_q  <= 1'b1;
`ifdef PISO_TX_PARITY_EN
            par_q   <= ^data_in;
`endif
          end else begin
            ser_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (last_bit) begin
`ifdef PISO_TX_PARITY_EN
            state_q <= PARITY;
            ser_q   <= par_q;
            done_q  <= 1'b1;
`else
            state_q <= IDLE;
            ser_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`endif
          end else begin
            shreg_q <= shreg_d;
            ser_q   <= next_bit;
`ifdef PISO_TX_PARITY_EN
            done_q  <= 1'b0;
`else
            // Flag the last data bit as it goes onto the line.
            done_q  <= (cnt == PEN_IDX);
`endif
          end
        end
`ifdef PISO_TX_PARITY_EN
        PARITY: begin
          state_q <= IDLE;
          ser_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
`endif
        default: begin
          state_q <= IDLE;
          ser_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ser_out = ser_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
